// File: rtl/pwm_fade_sequencer.sv
// Fade sequencer for the 8-bit PWM controller: ramps duty toward a commanded
// target one STEP per prescaler tick, or breathes 0<->target until released.
module pwm_fade_sequencer #(
  parameter int unsigned STEP   = 1,
  parameter int unsigned RATE_W = 18
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              breathe_en,
  output logic [7:0]        duty_cycle,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DW    = 8;
  localparam logic [DW:0] STEP9 = (DW+1)'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAMP    = 2'd1,
    ST_BREATHE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                dir_up_q, dir_up_d;
  logic [DW-1:0]       duty_q, duty_d;
  logic [DW-1:0]       target_q, target_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic [RATE_W-1:0]   cnt_q, cnt_d;
  logic                done_q, done_d;

  logic                accept;
  logic                tick;
  logic [DW-1:0]       goal;
  logic [DW:0]         sum9;
  logic [DW:0]         diff9;

  assign accept = cmd_valid && (state_q == ST_IDLE);
  assign tick   = (cnt_q == rate_q);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      dir_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
    end
  end

  // Next-state logic; in BREATHE the direction flips in the same cycle the
  // goal is reached so the turnaround costs no extra step period.
  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (breathe_en && (cmd_target != '0)) begin
            state_d  = ST_BREATHE;
            dir_up_d = 1'b1;
          end else begin
            state_d  = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (duty_q == target_q) state_d = ST_IDLE;
      end
      ST_BREATHE: begin
        if (dir_up_q && (duty_q == target_q)) begin
          dir_up_d = 1'b0;
        end else if (!dir_up_q && (duty_q == '0)) begin
          if (breathe_en) dir_up_d = 1'b1;
          else            state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / output next values: prescaler, saturating step, done pulse
  always_comb begin
    duty_d   = duty_q;
    target_d = target_q;
    rate_d   = rate_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    goal     = target_q;
    sum9     = {1'b0, duty_q} + STEP9;
    diff9    = {1'b0, duty_q} - STEP9;
    if ((state_q == ST_BREATHE) && !dir_up_d) goal = '0;

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (accept) begin
        target_d = cmd_target;
        rate_d   = cmd_rate;
      end
    end else if (state_d == ST_IDLE) begin
      done_d = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + RATE_W'(1);
      if (tick) begin
        if (duty_q < goal) begin
          duty_d = (sum9 >= {1'b0, goal}) ? goal : sum9[DW-1:0];
        end else if (duty_q > goal) begin
          duty_d = ({1'b0, duty_q} <= ({1'b0, goal} + STEP9)) ? goal : diff9[DW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      duty_q   <= '0;
      target_q <= '0;
      rate_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      duty_q   <= duty_d;
      target_q <= target_d;
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign duty_cycle = duty_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign cmd_ready  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed self-checking bench for pwm_fade_sequencer (STEP=1 and STEP=7 instances).
module tb_pwm_fade_sequencer;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic [7:0]  cmd_target;
  logic [17:0] cmd_rate;
  logic        breathe_en;

  logic        ready1, busy1, done1;
  logic [7:0]  duty1;
  logic        ready7, busy7, done7;
  logic [7:0]  duty7;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] breathe_seq [17] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0,
                                   8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

  pwm_fade_sequencer #(.STEP(1), .RATE_W(18)) u_dut1 (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(ready1),
    .cmd_target(cmd_target), .cmd_rate(cmd_rate), .breathe_en(breathe_en),
    .duty_cycle(duty1), .busy(busy1), .done(done1)
  );

  pwm_fade_sequencer #(.STEP(7), .RATE_W(18)) u_dut7 (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(ready7),
    .cmd_target(cmd_target), .cmd_rate(cmd_rate), .breathe_en(breathe_en),
    .duty_cycle(duty7), .busy(busy7), .done(done7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    cmd_valid  = 1'b0;
    breathe_en = 1'b0;
    rstn       = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Presents a command for one rising edge; returns at the following negedge.
  task automatic send_cmd(input logic [7:0] t, input logic [17:0] r, input logic b);
    cmd_target = t;
    cmd_rate   = r;
    breathe_en = b;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 1'b0; breathe_en = 1'b0;
    cmd_target = '0; cmd_rate = '0;
    #2;
    total_cnt++;
    if ({busy1, done1, ready1, duty1} !== {1'b0, 1'b0, 1'b1, 8'd0})
      $display("FAIL reset_state: got busy/done/ready/duty=%b%b%b/%0d want 001/0", busy1, done1, ready1, duty1);
    else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({busy1, done1, ready1, duty1, duty7} !== {1'b0, 1'b0, 1'b1, 8'd0, 8'd0})
        $display("FAIL reset_idle[%0d]: got busy/done/ready=%b%b%b duty1=%0d duty7=%0d want 001 0 0", k, busy1, done1, ready1, duty1, duty7);
      else pass_cnt++;
    end
  endtask

  task automatic test_ramp_up();
    do_reset();
    send_cmd(8'd10, 18'd3, 1'b0);
    total_cnt++;
    if ({busy1, done1, ready1, duty1} !== {1'b1, 1'b0, 1'b0, 8'd0})
      $display("FAIL ramp_accept: got busy/done/ready=%b%b%b duty=%0d want 100 0", busy1, done1, ready1, duty1);
    else pass_cnt++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({busy1, done1, duty1} !== {1'b1, 1'b0, 8'(k / 4)})
        $display("FAIL ramp_step[%0d]: got busy/done=%b%b duty=%0d want 10 %0d", k, busy1, done1, duty1, k / 4);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if ({busy1, done1, ready1, duty1} !== {1'b0, 1'b1, 1'b1, 8'd10})
      $display("FAIL ramp_done: got busy/done/ready=%b%b%b duty=%0d want 011 10", busy1, done1, ready1, duty1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done1, duty1} !== {1'b0, 8'd10})
      $display("FAIL ramp_done_pulse: got done=%b duty=%0d want 0 10", done1, duty1);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int n;
    int prev;
    logic bad;
    do_reset();
    send_cmd(8'd250, 18'd0, 1'b0);
    n = 0;
    while (done7 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total_cnt++;
    if (done7 !== 1'b1 || duty7 !== 8'd250)
      $display("FAIL sat_reach_250: got done=%b duty=%0d after %0d clk want 1 250", done7, duty7, n);
    else pass_cnt++;
    send_cmd(8'd255, 18'd0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (duty7 !== 8'd255)
      $display("FAIL sat_up_255: got duty=%0d want 255", duty7);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy7, done7, duty7} !== {1'b0, 1'b1, 8'd255})
      $display("FAIL sat_up_done: got busy/done=%b%b duty=%0d want 01 255", busy7, done7, duty7);
    else pass_cnt++;
    send_cmd(8'd3, 18'd0, 1'b0);
    n = 0; prev = 255; bad = 1'b0;
    while (done7 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (int'(duty7) < 3 || int'(duty7) > prev) bad = 1'b1;
      prev = int'(duty7);
    end
    total_cnt++;
    if (done7 !== 1'b1 || duty7 !== 8'd3 || n != 37)
      $display("FAIL sat_down_3: got done=%b duty=%0d after %0d clk want 1 3 after 37", done7, duty7, n);
    else pass_cnt++;
    total_cnt++;
    if (bad !== 1'b0)
      $display("FAIL sat_down_monotonic: got violation=%b want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_breathe();
    do_reset();
    send_cmd(8'd4, 18'd0, 1'b1);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      total_cnt++;
      if ({busy1, done1, duty1} !== {1'b1, 1'b0, breathe_seq[k]})
        $display("FAIL breathe_seq[%0d]: got busy/done=%b%b duty=%0d want 10 %0d", k, busy1, done1, duty1, breathe_seq[k]);
      else pass_cnt++;
      if (k == 11) breathe_en = 1'b0;
    end
    @(negedge clk);
    total_cnt++;
    if ({busy1, done1, ready1, duty1} !== {1'b0, 1'b1, 1'b1, 8'd0})
      $display("FAIL breathe_done: got busy/done/ready=%b%b%b duty=%0d want 011 0", busy1, done1, ready1, duty1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy1, done1, duty1} !== {1'b0, 1'b0, 8'd0})
      $display("FAIL breathe_idle: got busy/done=%b%b duty=%0d want 00 0", busy1, done1, duty1);
    else pass_cnt++;
  endtask

  task automatic test_handshake();
    do_reset();
    send_cmd(8'd20, 18'd1, 1'b0);
    cmd_valid  = 1'b1;
    cmd_target = 8'd5;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k % 10 == 0) begin
        total_cnt++;
        if ({busy1, duty1} !== {1'b1, 8'(k / 2)})
          $display("FAIL hs_ignore[%0d]: got busy=%b duty=%0d want 1 %0d", k, busy1, duty1, k / 2);
        else pass_cnt++;
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy1, done1, ready1, duty1} !== {1'b0, 1'b1, 1'b1, 8'd20})
      $display("FAIL hs_done: got busy/done/ready=%b%b%b duty=%0d want 011 20", busy1, done1, ready1, duty1);
    else pass_cnt++;
    send_cmd(8'd20, 18'd5, 1'b0);
    total_cnt++;
    if ({busy1, done1, ready1, duty1} !== {1'b1, 1'b0, 1'b0, 8'd20})
      $display("FAIL hs_same_busy: got busy/done/ready=%b%b%b duty=%0d want 100 20", busy1, done1, ready1, duty1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy1, done1, ready1, duty1} !== {1'b0, 1'b1, 1'b1, 8'd20})
      $display("FAIL hs_same_done: got busy/done/ready=%b%b%b duty=%0d want 011 20", busy1, done1, ready1, duty1);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy1, done1, duty1} !== {1'b0, 1'b0, 8'd20})
      $display("FAIL hs_same_idle: got busy/done=%b%b duty=%0d want 00 20", busy1, done1, duty1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    send_cmd(8'd200, 18'd0, 1'b0);
    repeat (100) @(negedge clk);
    total_cnt++;
    if ({busy1, duty1} !== {1'b1, 8'd100})
      $display("FAIL midrst_pre: got busy=%b duty=%0d want 1 100", busy1, duty1);
    else pass_cnt++;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if ({busy1, done1, ready1, duty1} !== {1'b0, 1'b0, 1'b1, 8'd0})
      $display("FAIL midrst_async: got busy/done/ready=%b%b%b duty=%0d want 001 0", busy1, done1, ready1, duty1);
    else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({busy1, done1, duty1} !== {1'b0, 1'b0, 8'd0})
        $display("FAIL midrst_after[%0d]: got busy/done=%b%b duty=%0d want 00 0", k, busy1, done1, duty1);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_saturation();
    test_breathe();
    test_handshake();
    test_reset_mid_ramp();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
